// File: rtl/booth_divider.sv
// booth_divider: signed 2W/W restoring divider. A result takes 2W+2 cycles, or 2 cycles on divide-by-zero. start is ignored while busy.
// Define DIV_OVF_CHECK_EN to build the quotient-overflow flag; otherwise ovf is a constant 0.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               ovf
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [DW-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_mag_q, dvs_mag_d;
    logic              neg_dvd_q, neg_dvd_d;
    logic              neg_dvs_q, neg_dvs_d;
    logic              dbz_q, dbz_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              div_by_zero_q, div_by_zero_d;

    logic              accept;
    logic [DW-1:0]     dvd_mag;
    logic [WIDTH-1:0]  dvs_mag;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;

    assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
    assign dvd_mag = dividend[DW-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;

    // R is always below |divisor|, so its top bit is zero between iterations and only
    // the shifted/trial values need the extra bit.
    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = shifted - {1'b0, dvs_mag_q};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_mag_d     = dvs_mag_q;
        neg_dvd_d     = neg_dvd_q;
        neg_dvs_d     = neg_dvs_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d         = '0;
                    rem_d         = '0;
                    dvs_mag_d     = dvs_mag;
                    neg_dvd_d     = dividend[DW-1];
                    neg_dvs_d     = divisor[WIDTH-1];
                    div_by_zero_d = 1'b0;
                    if (divisor == '0) begin
                        // Raw dividend is parked in Q so FIX can return its low bits.
                        dbz_d   = 1'b1;
                        quo_d   = dividend;
                        state_d = FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = dvd_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_q) begin
                    quotient_d    = '1;
                    remainder_d   = quo_q[WIDTH-1:0];
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d  = (neg_dvd_q ^ neg_dvs_q) ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
                    remainder_d = neg_dvd_q ? -rem_q : rem_q;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_mag_q     <= '0;
            neg_dvd_q     <= 1'b0;
            neg_dvs_q     <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_mag_q     <= dvs_mag_d;
            neg_dvd_q     <= neg_dvd_d;
            neg_dvs_q     <= neg_dvs_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

`ifdef DIV_OVF_CHECK_EN
    localparam logic [DW-1:0] Q_LIM_POS = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [DW-1:0] Q_LIM_NEG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

    logic ovf_q, ovf_d;

    // Q holds the unsigned magnitude, so a negative result may reach one more than a positive one.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if ((state_q == FIX) && !dbz_q) begin
            ovf_d = (neg_dvd_q ^ neg_dvs_q) ? (quo_q > Q_LIM_NEG) : (quo_q > Q_LIM_POS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_booth_divider.sv
// Testbench for booth_divider: directed vector table, handshake corner sequences, and randomized ops against an arithmetic model.
module tb_booth_divider;

`ifdef DIV_OVF_CHECK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    booth_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ov;
        int          cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Issues one op from IDLE/DONE; returns edges counted from the accepting edge until done.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int cyc);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dbz, output logic ov, output int cyc);
        int sa, sb, qt, rt;
        logic [31:0] qv, rv;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            q = 8'hFF; r = a[7:0]; dbz = 1'b1; ov = 1'b0; cyc = 2;
        end else begin
            qt = sa / sb;
            rt = sa % sb;
            qv = qt;
            rv = rt;
            q = qv[7:0]; r = rv[7:0]; dbz = 1'b0; cyc = 18;
            ov = OVF_ON && (qt > 127 || qt < -128);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int cyc;
        logic [7:0] eq, er;
        logic edbz, eov;
        int ecyc;

        vecs[0] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0,   18};
        vecs[1] = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0,   18};
        vecs[2] = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0,   18};
        vecs[3] = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0,   18};
        vecs[4] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0,    2};
        vecs[5] = '{16'h4000, 8'h02, 8'h00, 8'h00, 1'b0, OVF_ON, 18};
        vecs[6] = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0,   18};
        vecs[7] = '{16'h8000, 8'hFF, 8'h00, 8'h00, 1'b0, OVF_ON, 18};
        vecs[8] = '{16'h0001, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0,   18};
        vecs[9] = '{16'hFFFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0,   18};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_q", i), quotient, vecs[i].q);
            check($sformatf("vec%0d_r", i), remainder, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // start while busy is ignored, and changing inputs mid-op has no effect
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        dividend = 16'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        cyc++; start = 1'b0;
        check("busy_mid_calc", busy, 1);
        wait_done(cyc);
        check("ignored_start_cycles", cyc, 18);
        check("ignored_start_q", quotient, 8'h0E);
        check("ignored_start_r", remainder, 8'h02);

        // start accepted in DONE drops done at the same edge
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        check("restart_done_drop", done, 0);
        check("restart_busy", busy, 1);
        wait_done(cyc);
        check("restart_cycles", cyc, 18);
        check("restart_q", quotient, 8'h0A);
        check("restart_r", remainder, 8'h00);

        // start held high: back-to-back ops, done lasts a single cycle
        dividend = 16'hFF9C; divisor = 8'h07; start = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 40);
        check("held_first_cycles", cyc, 18);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) check("held_done_drop", done, 0);
        end while (!done && cyc < 40);
        start = 1'b0;
        check("held_second_cycles", cyc, 18);
        check("held_q", quotient, 8'hF2);

        // synchronous reset during CALC cycle 6
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst_busy", busy, 0);
        run_op(16'd100, 8'd7, cyc);
        check("after_rst_cycles", cyc, 18);
        check("after_rst_q", quotient, 8'h0E);
        check("after_rst_r", remainder, 8'h02);

        // randomized ops against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            if ($urandom_range(0, 2) != 0) a = {{4{a[11]}}, a[11:0]};
            case ($urandom_range(0, 9))
                0:       b = 8'h00;
                1:       b = 8'h80;
                2:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            model(a, b, eq, er, edbz, eov, ecyc);
            run_op(a, b, cyc);
            check($sformatf("rand%0d_cycles a=%h b=%h", i, a, b), cyc, ecyc);
            check($sformatf("rand%0d_q a=%h b=%h", i, a, b), quotient, eq);
            check($sformatf("rand%0d_r a=%h b=%h", i, a, b), remainder, er);
            check($sformatf("rand%0d_dbz a=%h b=%h", i, a, b), div_by_zero, edbz);
            check($sformatf("rand%0d_ovf a=%h b=%h", i, a, b), ovf, eov);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
